// File: rtl/shifter_unit_if.sv
// Shifter request/response bundle.
// Master issues the shift request, slave returns the shifter operand.
interface shifter_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       shift_type;
  logic             amount_is_reg;
  logic [4:0]       shift_imm;
  logic [7:0]       rs_amount;
  logic [WIDTH-1:0] rm;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, shift_type, amount_is_reg,
    output shift_imm, rs_amount, rm, carry_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, shift_type, amount_is_reg,
    input  shift_imm, rs_amount, rm, carry_in,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/shifter_unit.sv
// Iterative ARM data-processing shifter.
// Shifts one bit per clock; RRX is ROR #0 on the immediate path.
module shifter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  shifter_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   k_eff;
  logic               rrx_sel;
  logic [4:0]         n_m1;
  logic [WIDTH-1:0]   work;
  logic               wc;
  logic [1:0]         op;
  logic               rrx;
  logic [WIDTH-1:0]   step_w;
  logic               step_c;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

  assign n_m1 = bus.rs_amount[4:0] - 5'd1;

  // Effective step count and RRX detection from the request
  always_comb begin
    k_eff   = '0;
    rrx_sel = 1'b0;
    if (bus.amount_is_reg) begin
      unique case (bus.shift_type)
        2'b00, 2'b01:
          k_eff = (bus.rs_amount > 8'd33) ?
                  CNT_W'(33) : CNT_W'(bus.rs_amount);
        2'b10:
          k_eff = (bus.rs_amount > 8'd32) ?
                  CNT_W'(32) : CNT_W'(bus.rs_amount);
        default:
          k_eff = (bus.rs_amount == 8'd0) ?
                  '0 : CNT_W'(n_m1) + CNT_W'(1);
      endcase
    end else begin
      unique case (bus.shift_type)
        2'b00:
          k_eff = CNT_W'(bus.shift_imm);
        2'b01, 2'b10:
          k_eff = (bus.shift_imm == 5'd0) ?
                  CNT_W'(32) : CNT_W'(bus.shift_imm);
        default: begin
          if (bus.shift_imm == 5'd0) begin
            k_eff   = CNT_W'(1);
            rrx_sel = 1'b1;
          end else begin
            k_eff = CNT_W'(bus.shift_imm);
          end
        end
      endcase
    end
  end

  // One-bit step of the working register and carry
  always_comb begin
    step_w = work;
    step_c = wc;
    if (rrx) begin
      step_w = {wc, work[WIDTH-1:1]};
      step_c = work[0];
    end else begin
      unique case (op)
        2'b00: begin
          step_w = {work[WIDTH-2:0], 1'b0};
          step_c = work[WIDTH-1];
        end
        2'b01: begin
          step_w = {1'b0, work[WIDTH-1:1]};
          step_c = work[0];
        end
        2'b10: begin
          step_w = {work[WIDTH-1], work[WIDTH-1:1]};
          step_c = work[0];
        end
        default: begin
          step_w = {work[0], work[WIDTH-1:1]};
          step_c = work[0];
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (bus.start)
          state_d = (k_eff == '0) ? FINISH : SHIFT;
      SHIFT:
        if (cnt == CNT_W'(1)) state_d = FINISH;
      FINISH:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Working datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      work     <= '0;
      wc       <= 1'b0;
      op       <= 2'b00;
      rrx      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.rm;
            wc     <= bus.carry_in;
            cnt    <= k_eff;
            op     <= bus.shift_type;
            rrx    <= rrx_sel;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          work <= step_w;
          wc   <= step_c;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) busy_q <= 1'b0;
        end
        FINISH: begin
          result_q <= work;
          carry_q  <= wc;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
